clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel, runtime-programmable integer clock divider; successor to the fixed power-of-two divider. Each of NUM_CH channels divides clk_in by an arbitrary integer in 2..2^DIV_W-1. Each channel produces a registered divided clock and a one-cycle tick strobe marking each period start. Used to derive slow clock enables (sample strobes, pipeline pacing) for the NN datapath from one system clock.

## Interface
- NUM_CH, 4, number of independent divider channels (>=1)
- DIV_W, 8, divisor width in bits (>=2)
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (0..2^DIV_W-1)
- SEL_W, $clog2(NUM_CH) (min 1), width of channel select (derived, not overridden)

- clk_in  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- div_we  input  1  write strobe for pending divisor
- div_sel  input  SEL_W  channel index for write
- div_data  input  DIV_W  new divisor value
- sync_restart  input  1  phase-align all channels (present only with CLKDIV_SYNC_RESTART_EN)
- clk_out  output  NUM_CH  divided clock per channel, registered
- tick  output  NUM_CH  one-cycle period-start strobe per channel, registered

## Operation
- Per channel state: cnt (DIV_W), active divisor act (DIV_W), pending divisor pend (DIV_W).
- Reset (async, while rst_n=0): cnt=0, act=pend=DEFAULT_DIV, clk_out=0, tick=0, channel flagged "wrap pending" so the first edge after release starts a period.
- Wrap condition: wrap pending flag, or act>=1 and cnt==act-1, or act==0 (stopped).
- On wrap edge: act<=pend; if new act!=0, cnt<=0 and tick<=1, else cnt<=0 and tick<=0.
- Otherwise: cnt<=cnt+1, tick<=0.
- clk_out <= (cnt_next < act_next>>1) for act_next>=2; 0 for act_next<=1. Result: high for floor(N/2) cycles, low for ceil(N/2) cycles. Exactly 50% for even N, one cycle less high for odd N.
- N=1: tick every cycle, clk_out held 0. N=0: channel stopped, tick and clk_out 0, cnt held 0.
- Write: div_we=1 at an edge stores div_data into pend[div_sel]. div_sel>=NUM_CH is ignored. act changes only at that channel's next wrap, so a divisor change never produces a runt period.
- Write and wrap on the same edge: the wrap uses the old pend. The new value applies at the following wrap.
- Stopped channel (act=0): a write at edge k starts the channel at edge k+1 (tick=1 at k+1).
- Channels are fully independent; simultaneous wraps are allowed.

## Timing
- First tick: 1 edge after rst_n deasserts (the first posedge with rst_n=1).
- Period: exactly act edges between consecutive ticks.
- Divisor change latency: write at edge k → new period length from the first wrap edge strictly after k.
- All outputs are flops; no combinational path from inputs to outputs.
- Reset asserted mid-period: outputs cleared immediately (async), regardless of clk_in.

## Configuration
- CLKDIV_SYNC_RESTART_EN defined:
  - The sync_restart port exists.
  - sync_restart=1 at an edge forces a wrap on every channel simultaneously, overriding normal counting.
  - Each channel does act<=pend, cnt<=0, tick<=(pend!=0).
  - A div_we on the same edge lands in pend after the restart; the restart uses the old pend.
- CLKDIV_SYNC_RESTART_EN undefined:
  - No sync_restart port and no restart logic.
  - Channels align only via reset.

## Test plan
- Reset, DEFAULT_DIV=2, NUM_CH=4 → tick on all channels at edges 1,3,5…; clk_out toggles 1,0,1,0 starting at edge 1.
- Write ch1=5 mid-period (cnt=0 of divide-by-2) → current 2-cycle period completes; then ticks every 5 edges; clk_out high 2, low 3. Other channels unchanged.
- Write ch2=0 → ch2 stops at its next wrap (tick/clk_out 0). Later write 3 at edge k → tick at k+1, then every 3.
- Write ch0=7 on the exact edge ch0 wraps → one more period at the old divisor, then 7-cycle periods. Write with div_sel=5 (NUM_CH=4) → no channel changes.
- Divisor 1 and 255 (DIV_W=8) → tick every edge / every 255 edges; clk_out constant 0 / high 127, low 128.
- With CLKDIV_SYNC_RESTART_EN, channels at divisors 3, 4, 5, 6 in arbitrary phase, pulse sync_restart → all ticks coincide on that edge; next coincidence 60 edges later. Assert rst_n low mid-period → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable integer clock divider with registered clock and tick outputs.
// Define CLKDIV_SYNC_RESTART_EN to add the sync_restart port that phase-aligns all channels.
module clock_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2,
    localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              div_we,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_data,
`ifdef CLKDIV_SYNC_RESTART_EN
    input  logic              sync_restart,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  cnt_d  [NUM_CH];
    logic [DIV_W-1:0]  act_q  [NUM_CH];
    logic [DIV_W-1:0]  act_d  [NUM_CH];
    logic [DIV_W-1:0]  pend_q [NUM_CH];
    logic [DIV_W-1:0]  pend_d [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] wrap_c;
    logic              wrap_pend_q;

    // Per-channel next state; a wrap always adopts the pre-edge pending divisor.
    always_comb begin
        wrap_c    = '0;
        clk_out_d = '0;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            pend_d[i] = pend_q[i];

            wrap_c[i] = wrap_pend_q
                      || (act_q[i] == '0)
                      || (cnt_q[i] == act_q[i] - DIV_W'(1));
`ifdef CLKDIV_SYNC_RESTART_EN
            wrap_c[i] = wrap_c[i] || sync_restart;
`endif

            if (div_we && (div_sel == SEL_W'(i))) begin
                pend_d[i] = div_data;
            end

            if (wrap_c[i]) begin
                act_d[i]  = pend_q[i];
                cnt_d[i]  = '0;
                tick_d[i] = (pend_q[i] != '0);
            end else begin
                cnt_d[i]  = cnt_q[i] + DIV_W'(1);
                tick_d[i] = 1'b0;
            end

            // High for floor(N/2) cycles of each period; held low for N<=1.
            clk_out_d[i] = (act_d[i] >= DIV_W'(2)) && (cnt_d[i] < (act_d[i] >> 1));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pend_q <= 1'b1;
            clk_out_q   <= '0;
            tick_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= DIV_W'(DEFAULT_DIV);
                pend_q[i] <= DIV_W'(DEFAULT_DIV);
            end
        end else begin
            wrap_pend_q <= 1'b0;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                act_q[i]  <= act_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed-vector bench for clock_divider_multi (NUM_CH=4, DIV_W=8, DEFAULT_DIV=2).
module tb_clock_divider_multi;

    logic       clk_in;
    logic       rst_n;
    logic       div_we;
    logic [1:0] div_sel;
    logic [7:0] div_data;
    logic [3:0] clk_out;
    logic [3:0] tick;
`ifdef CLKDIV_SYNC_RESTART_EN
    logic       sync_restart;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    clock_divider_multi #(
        .NUM_CH      (4),
        .DIV_W       (8),
        .DEFAULT_DIV (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .div_we       (div_we),
        .div_sel      (div_sel),
        .div_data     (div_data),
`ifdef CLKDIV_SYNC_RESTART_EN
        .sync_restart (sync_restart),
`endif
        .clk_out      (clk_out),
        .tick         (tick)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic wr_step(input logic [1:0] sel, input logic [7:0] data);
        div_we   = 1'b1;
        div_sel  = sel;
        div_data = data;
        step();
        div_we   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        div_we   = 1'b0;
        div_sel  = '0;
        div_data = '0;
`ifdef CLKDIV_SYNC_RESTART_EN
        sync_restart = 1'b0;
`endif
        #2;
        chk4("rst_tick", tick, 4'b0000);
        chk4("rst_clk", clk_out, 4'b0000);
        @(posedge clk_in);
        #1;
        chk4("rst_hold_tick", tick, 4'b0000);
        chk4("rst_hold_clk", clk_out, 4'b0000);

        @(negedge clk_in);
        rst_n  = 1'b1;
        edge_n = 0;

        // Default divide-by-2 on all channels
        step();  chk4("e1_tick", tick, 4'b1111); chk4("e1_clk", clk_out, 4'b1111);
        step();  chk4("e2_tick", tick, 4'b0000); chk4("e2_clk", clk_out, 4'b0000);
        step();  chk4("e3_tick", tick, 4'b1111); chk4("e3_clk", clk_out, 4'b1111);

        // ch1 <- 5 mid-period
        wr_step(2'd1, 8'd5);
        chk4("e4_tick", tick, 4'b0000); chk4("e4_clk", clk_out, 4'b0000);
        step();  chk4("e5_tick", tick, 4'b1111); chk4("e5_clk", clk_out, 4'b1111);
        step();  chk4("e6_tick", tick, 4'b0000); chk4("e6_clk", clk_out, 4'b0010);
        step();  chk4("e7_tick", tick, 4'b1101); chk4("e7_clk", clk_out, 4'b1101);
        step();  chk4("e8_tick", tick, 4'b0000); chk4("e8_clk", clk_out, 4'b0000);
        step();  chk4("e9_tick", tick, 4'b1101); chk4("e9_clk", clk_out, 4'b1101);
        step();  chk4("e10_tick", tick, 4'b0010); chk4("e10_clk", clk_out, 4'b0010);

        // ch2 <- 0 on its wrap edge: one more divide-by-2 period, then stopped
        wr_step(2'd2, 8'd0);
        chk4("e11_tick", tick, 4'b1101); chk4("e11_clk", clk_out, 4'b1111);
        step();  chk4("e12_tick", tick, 4'b0000); chk4("e12_clk", clk_out, 4'b0000);
        step();  chk4("e13_tick", tick, 4'b1001); chk4("e13_clk", clk_out, 4'b1001);
        step();  chk4("e14_tick", tick, 4'b0000); chk4("e14_clk", clk_out, 4'b0000);
        step();  chk4("e15_tick", tick, 4'b1011); chk4("e15_clk", clk_out, 4'b1011);

        // Restart stopped ch2 with 3: tick one edge after the write
        wr_step(2'd2, 8'd3);
        chk4("e16_tick", tick, 4'b0000); chk4("e16_clk", clk_out, 4'b0010);
        step();  chk4("e17_tick", tick, 4'b1101); chk4("e17_clk", clk_out, 4'b1101);
        step();  chk4("e18_tick", tick, 4'b0000); chk4("e18_clk", clk_out, 4'b0000);
        step();  chk4("e19_tick", tick, 4'b1001); chk4("e19_clk", clk_out, 4'b1001);
        step();  chk4("e20_tick", tick, 4'b0110); chk4("e20_clk", clk_out, 4'b0110);

        // ch0 <- 7 on its exact wrap edge
        wr_step(2'd0, 8'd7);
        chk4("e21_tick", tick, 4'b1001); chk4("e21_clk", clk_out, 4'b1011);
        step();  chk4("e22_tick", tick, 4'b0000); chk4("e22_clk", clk_out, 4'b0000);
        step();  chk4("e23_tick", tick, 4'b1101); chk4("e23_clk", clk_out, 4'b1101);
        step();  chk1("e24_ch0_tick", tick[0], 1'b0); chk1("e24_ch0_clk", clk_out[0], 1'b1);
        step();  chk1("e25_ch0_clk", clk_out[0], 1'b1);
        step();  chk1("e26_ch0_clk", clk_out[0], 1'b0);
        run_to(29);
        chk1("e29_ch0_tick", tick[0], 1'b0);
        step();  chk1("e30_ch0_tick", tick[0], 1'b1); chk1("e30_ch0_clk", clk_out[0], 1'b1);

        // ch3 <- 1, ch1 <- 255
        wr_step(2'd3, 8'd1);
        chk1("e31_ch3_tick", tick[3], 1'b1); chk1("e31_ch3_clk", clk_out[3], 1'b1);
        wr_step(2'd1, 8'd255);
        chk1("e32_ch3_tick", tick[3], 1'b0); chk1("e32_ch3_clk", clk_out[3], 1'b0);
        step();  chk1("e33_ch3_tick", tick[3], 1'b1); chk1("e33_ch3_clk", clk_out[3], 1'b0);
        step();  chk1("e34_ch3_tick", tick[3], 1'b1); chk1("e34_ch3_clk", clk_out[3], 1'b0);
        step();  chk1("e35_ch1_tick", tick[1], 1'b1); chk1("e35_ch1_clk", clk_out[1], 1'b1);
        chk1("e35_ch3_tick", tick[3], 1'b1);
        run_to(161);
        chk1("e161_ch1_clk", clk_out[1], 1'b1);
        step();  chk1("e162_ch1_clk", clk_out[1], 1'b0);
        run_to(289);
        chk1("e289_ch1_tick", tick[1], 1'b0); chk1("e289_ch1_clk", clk_out[1], 1'b0);
        step();  chk4("e290_tick", tick, 4'b1110); chk4("e290_clk", clk_out, 4'b0111);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk4("async_rst_tick", tick, 4'b0000);
        chk4("async_rst_clk", clk_out, 4'b0000);

`ifdef CLKDIV_SYNC_RESTART_EN
        @(negedge clk_in);
        rst_n  = 1'b1;
        edge_n = 0;
        wr_step(2'd0, 8'd3);
        wr_step(2'd1, 8'd4);
        wr_step(2'd2, 8'd5);
        wr_step(2'd3, 8'd6);
        run_to(10);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk4("sr_e11_tick", tick, 4'b1111); chk4("sr_e11_clk", clk_out, 4'b1111);
        step();  chk4("sr_e12_tick", tick, 4'b0000);
        run_to(23);
        chk4("sr_e23_tick", tick, 4'b1011);
        run_to(70);
        chk4("sr_e70_tick", tick, 4'b0000);
        step();  chk4("sr_e71_tick", tick, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("sr_async_rst_tick", tick, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
